// File: rtl/hex_scan_driver.sv
// Scans a DIGITS*4-bit word onto a 4-bit hex decoder one digit at a time.
// The displayed outputs change the cycle after a slot tick. A new word is shown from the next frame.
// There is no backpressure: every load is accepted and the last load before a frame boundary wins.
//
// Ports:
//   clk, reset             single rising-edge clock; async active-high reset
//   load, value            1-cycle strobe capturing value (DIGITS*4 bits)
//   lz_blank, blink_en     level inputs: leading-zero suppression, whole-display blink
//   load_ack               1-cycle pulse when a loaded word becomes the displayed word
//   num, digit_sel, blank  current nibble, one-hot digit select, blank request
module hex_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DIGITS*4-1:0]   value,
  input  logic                  lz_blank,
  input  logic                  blink_en,
  output logic                  load_ack,
  output logic [3:0]            num,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  blank
);

  localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int IW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PS_MAX  = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FC_MAX  = FW'(BLINK_DIV - 1);

  logic [PW-1:0]         prescaler;
  logic [IW-1:0]         idx;
  logic [DIGITS*4-1:0]   active;
  logic [DIGITS*4-1:0]   shadow;
  logic                  pending;
  logic [FW-1:0]         frame_cnt;
  logic                  phase;

  logic                  tick;
  logic                  frame_end;
  logic [DIGITS-1:0]     lz_mask;
  logic                  zero_above;

  assign tick      = (prescaler == PS_MAX);
  assign frame_end = tick && (idx == IDX_MAX);

  // Slot timing: prescaler divides clk down to one digit slot, idx walks the digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      idx       <= '0;
    end else begin
      if (tick) begin
        prescaler <= '0;
        idx       <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

  // Double-buffered word: loads land in shadow and are promoted only at a frame
  // boundary so a frame never mixes nibbles from two words. A load arriving
  // exactly on the boundary bypasses the shadow and drops any stale pending word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active   <= '0;
      shadow   <= '0;
      pending  <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      if (frame_end) begin
        pending  <= 1'b0;
        load_ack <= load || pending;
        if (load) begin
          active <= value;
        end else if (pending) begin
          active <= shadow;
        end
      end else begin
        load_ack <= 1'b0;
        if (load) begin
          shadow  <= value;
          pending <= 1'b1;
        end
      end
    end
  end

  // Blink timebase: counts frames regardless of blink_en so enabling blink
  // mid-run stays locked to the frame cadence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FC_MAX) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  // lz_mask[i] is set when nibbles DIGITS-1 down to i are all zero. Digit 0 is
  // never masked so a zero word still shows one "0".
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (active[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_above;
    end
  end

  assign num       = active[4*idx +: 4];
  assign digit_sel = DIGITS'(1) << idx;
  assign blank     = (lz_blank & lz_mask[idx]) | (blink_en & phase);

endmodule

// File: tb/tb_hex_scan_driver.sv
module tb_hex_scan_driver;

  localparam int DIG   = 4;
  localparam int SCAN  = 4;
  localparam int BD    = 2;
  localparam int FRAME = DIG * SCAN;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        lz_blank = 1'b0;
  logic        blink_en = 1'b0;
  logic        load_ack;
  logic [3:0]  num;
  logic [3:0]  digit_sel;
  logic        blank;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0;

  hex_scan_driver #(.DIGITS(DIG), .SCAN_DIV(SCAN), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .lz_blank(lz_blank), .blink_en(blink_en), .load_ack(load_ack),
    .num(num), .digit_sel(digit_sel), .blank(blank)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset decides slot, frame and blink phase;
  // a word loaded during a frame becomes visible at the next frame start.
  int          mt;      // cycles since reset release
  logic [15:0] ma;      // word on display
  logic [15:0] mw;      // most recent load waiting for a frame boundary
  logic        mpend;
  logic        mack;
  wire         m_fe = ((mt % FRAME) == FRAME - 1);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mt <= 0; ma <= '0; mw <= '0; mpend <= 1'b0; mack <= 1'b0;
    end else begin
      mt <= mt + 1;
      if (m_fe) begin
        mack  <= load | mpend;
        mpend <= 1'b0;
        if (load) ma <= value;
        else if (mpend) ma <= mw;
      end else begin
        mack <= 1'b0;
        if (load) begin
          mw <= value; mpend <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int e_idx, e_lz, e_phase;
    e_idx   = (mt / SCAN) % DIG;
    e_lz    = (e_idx > 0 && lz_blank && ((ma >> (4 * e_idx)) == 16'h0)) ? 1 : 0;
    e_phase = ((mt / FRAME) / BD) % 2;
    chk("model_num", int'(num), int'((ma >> (4 * e_idx)) & 16'hF));
    chk("model_sel", int'(digit_sel), 1 << e_idx);
    chk("model_blank", int'(blank), e_lz | (int'(blink_en) & e_phase));
    chk("model_ack", int'(load_ack), int'(mack));
  end

  always @(negedge clk) if (load_ack) ack_cnt <= ack_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Align so the next posedge sees frame position k.
  task automatic to_mod(input int k);
    for (int i = 0; i < 64; i++) begin
      if ((mt % FRAME) == k) return;
      tick();
    end
    chk("align_timeout", 0, 1);
  endtask

  task automatic to_t(input int x);
    for (int i = 0; i < 400; i++) begin
      if (mt == x) return;
      tick();
    end
    chk("time_timeout", 0, 1);
  endtask

  // Leaves the caller at the negedge of the ack cycle.
  task automatic wait_ack();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (load_ack) return;
    end
    chk("ack_timeout", 0, 1);
  endtask

  task automatic load_word(input logic [15:0] w);
    load = 1'b1; value = w;
    tick();
    load = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int a0;
    // 1: reset and idle scan
    tick(); tick();
    @(negedge clk);
    chk("rst_sel", int'(digit_sel), 1);
    chk("rst_num", int'(num), 0);
    chk("rst_blank", int'(blank), 0);
    chk("rst_ack", int'(load_ack), 0);
    reset = 1'b0;
    to_t(5);
    @(negedge clk);
    chk("idle_sel_slot1", int'(digit_sel), 2);
    to_t(40);
    chk("idle_no_ack", ack_cnt, 0);

    // 2: mid-frame load held until frame end
    do_reset();
    to_mod(5);
    a0 = ack_cnt;
    load_word(16'hBEEF);
    @(negedge clk);
    chk("beef_before_frame", int'(num), 0);
    wait_ack();
    chk("beef_d0", int'(num), 4'hF);
    chk("beef_sel0", int'(digit_sel), 1);
    repeat (4) @(negedge clk);
    chk("beef_d1", int'(num), 4'hE);
    repeat (4) @(negedge clk);
    chk("beef_d2", int'(num), 4'hE);
    repeat (4) @(negedge clk);
    chk("beef_d3", int'(num), 4'hB);
    chk("beef_sel3", int'(digit_sel), 8);
    tick(); to_mod(8);
    chk("beef_one_ack", ack_cnt - a0, 1);

    // 3: two loads in one frame, last wins
    to_mod(2);
    a0 = ack_cnt;
    load_word(16'h1234);
    tick(); tick();
    load_word(16'h5678);
    wait_ack();
    chk("last_wins_d0", int'(num), 8);
    repeat (12) @(negedge clk);
    chk("last_wins_d3", int'(num), 5);
    tick(); to_mod(8);
    chk("last_wins_one_ack", ack_cnt - a0, 1);

    // 4: leading-zero blanking
    lz_blank = 1'b1;
    to_mod(3);
    load_word(16'h0040);
    wait_ack();
    chk("lz40_d0_blank", int'(blank), 0);
    repeat (4) @(negedge clk);
    chk("lz40_d1_blank", int'(blank), 0);
    chk("lz40_d1_num", int'(num), 4);
    repeat (4) @(negedge clk);
    chk("lz40_d2_blank", int'(blank), 1);
    repeat (4) @(negedge clk);
    chk("lz40_d3_blank", int'(blank), 1);
    tick();
    load_word(16'h0000);
    wait_ack();
    chk("lz0_d0_blank", int'(blank), 0);
    chk("lz0_d0_num", int'(num), 0);
    repeat (4) @(negedge clk);
    chk("lz0_d1_blank", int'(blank), 1);
    tick();
    lz_blank = 1'b0;

    // 5: blink, 2 frames on / 2 off
    do_reset();
    blink_en = 1'b1;
    to_t(8);  @(negedge clk); chk("blink_f0", int'(blank), 0);
    tick(); to_t(24); @(negedge clk); chk("blink_f1", int'(blank), 0);
    tick(); to_t(40); @(negedge clk); chk("blink_f2", int'(blank), 1);
    tick(); to_t(56); @(negedge clk); chk("blink_f3", int'(blank), 1);
    tick(); to_t(72); @(negedge clk); chk("blink_f4", int'(blank), 0);
    tick();
    blink_en = 1'b0;

    // 6: load on frame end, then reset while pending
    to_mod(15);
    load_word(16'hA5A5);
    @(negedge clk);
    chk("coinc_ack", int'(load_ack), 1);
    chk("coinc_d0", int'(num), 5);
    tick(); to_mod(3);
    load_word(16'h1234);
    a0 = ack_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("rstp_num", int'(num), 0);
    chk("rstp_sel", int'(digit_sel), 1);
    chk("rstp_ack", int'(load_ack), 0);
    tick();
    reset = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    chk("rstp_no_ack", ack_cnt - a0, 0);
    chk("rstp_num_after", int'(num), 0);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      tick();
      load  = ($urandom_range(0, 5) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 7) == 0) value = value & 16'h00FF;
      if ($urandom_range(0, 40) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 60) == 0) blink_en = ~blink_en;
      if ($urandom_range(0, 400) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end
    tick();
    load = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
